// File: rtl/adc_spi_sampler.sv
// ADC128S022 front end: continuous single-channel conversion, 16-bit frame deserialiser,
// optional box-car averaging, and a held 12-bit result for the thermometer comparator.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | cs_n high, sclk high; waits for enable
// S_CS_SETUP | cs_n low, sclk high for CLK_DIV cycles before the first fall
// S_SHIFT    | 16 slots, each a low phase then a high phase of CLK_DIV cycles
// S_CS_HOLD  | cs_n low, sclk high for CLK_DIV cycles after the last rise
// S_GAP      | cs_n high for GAP_CYCLES, then next frame or back to idle
module adc_spi_sampler #(
   parameter int CLK_DIV    = 25,
   parameter int CHANNEL    = 0,
   parameter int AVG_LOG2   = 2,
   parameter int GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic        adc_din,
   input  logic        adc_miso,
   output logic [11:0] adc_dout,
   output logic        adc_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CS_SETUP,
      S_SHIFT,
      S_CS_HOLD,
      S_GAP
   } state_t;

   localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int ACC_W   = 12 + AVG_LOG2;
   localparam int CNT_W   = AVG_LOG2 + 1;

   localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [15:0]      DIN_WORD = {2'b00, 3'(CHANNEL), 11'd0};

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   tmr, tmr_nxt, tmr_dec;
   logic [3:0]         slot, slot_nxt;
   logic               hi_phase, hi_nxt;

   logic               cs_n_d, sclk_d, din_d;
   logic               sample_en, frame_done;

   logic [11:0]        shreg;
   logic [ACC_W-1:0]   acc, sum;
   logic [CNT_W-1:0]   cnt;
   logic               primed;

   assign tmr_dec = tmr - TMR_ONE;
   assign sum     = acc + ACC_W'(shreg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tmr      <= '0;
         slot     <= '0;
         hi_phase <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         slot     <= slot_nxt;
         hi_phase <= hi_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      slot_nxt  = slot;
      hi_nxt    = hi_phase;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt = S_CS_SETUP;
               tmr_nxt   = DIV_LOAD;
            end
         end
         S_CS_SETUP: begin
            if (tmr == '0) begin
               state_nxt = S_SHIFT;
               tmr_nxt   = DIV_LOAD;
               slot_nxt  = '0;
               hi_nxt    = 1'b0;
            end else begin
               tmr_nxt = tmr_dec;
            end
         end
         S_SHIFT: begin
            if (tmr == '0) begin
               tmr_nxt = DIV_LOAD;
               if (!hi_phase) begin
                  hi_nxt = 1'b1;
               end else if (slot == 4'd15) begin
                  state_nxt = S_CS_HOLD;
               end else begin
                  slot_nxt = slot + 4'd1;
                  hi_nxt   = 1'b0;
               end
            end else begin
               tmr_nxt = tmr_dec;
            end
         end
         S_CS_HOLD: begin
            if (tmr == '0) begin
               state_nxt = S_GAP;
               tmr_nxt   = GAP_LOAD;
            end else begin
               tmr_nxt = tmr_dec;
            end
         end
         S_GAP: begin
            if (tmr == '0) begin
               if (enable) begin
                  state_nxt = S_CS_SETUP;
                  tmr_nxt   = DIV_LOAD;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               tmr_nxt = tmr_dec;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus pins are decoded from the next state so the registered pins line up with the state
   always_comb begin
      cs_n_d     = 1'b1;
      sclk_d     = 1'b1;
      din_d      = 1'b0;
      sample_en  = (state == S_SHIFT) && !hi_phase && (tmr == '0);
      frame_done = (state == S_CS_HOLD) && (tmr == '0);
      case (state_nxt)
         S_CS_SETUP, S_CS_HOLD: cs_n_d = 1'b0;
         S_SHIFT: begin
            cs_n_d = 1'b0;
            sclk_d = hi_nxt;
            din_d  = DIN_WORD[4'd15 - slot_nxt];
         end
         default: ;
      endcase
   end

   // A 12-bit shifter fed all 16 slots naturally drops the four leading zero bits
   always_ff @(posedge clk) begin
      if (rst) begin
         adc_cs_n  <= 1'b1;
         adc_sclk  <= 1'b1;
         adc_din   <= 1'b0;
         adc_dout  <= 12'd4095;
         adc_valid <= 1'b0;
         shreg     <= '0;
         acc       <= '0;
         cnt       <= '0;
         primed    <= 1'b0;
      end else begin
         adc_cs_n  <= cs_n_d;
         adc_sclk  <= sclk_d;
         adc_din   <= din_d;
         adc_valid <= 1'b0;
         if (sample_en) begin
            shreg <= {shreg[10:0], adc_miso};
         end
         if (state == S_IDLE) begin
            acc    <= '0;
            cnt    <= '0;
            primed <= 1'b0;
         end else if (frame_done) begin
            if (!primed) begin
               primed <= 1'b1;
            end else if (cnt == CNT_LAST) begin
               adc_dout  <= 12'(sum >> AVG_LOG2);
               adc_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: three instances with identical bus timing share one
// ADC bus model, differing only in channel and averaging depth.
module tb_adc_spi_sampler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        miso = 1'b0;

   logic        cs_n_a, sclk_a, din_a, valid_a;
   logic        cs_n_b, sclk_b, din_b, valid_b;
   logic        cs_n_c, sclk_c, din_c, valid_c;
   logic [11:0] dout_a, dout_b, dout_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adc_spi_sampler #(.CLK_DIV(2), .CHANNEL(5), .AVG_LOG2(0), .GAP_CYCLES(4)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .adc_cs_n(cs_n_a), .adc_sclk(sclk_a),
      .adc_din(din_a), .adc_miso(miso), .adc_dout(dout_a), .adc_valid(valid_a));

   adc_spi_sampler #(.CLK_DIV(2), .CHANNEL(0), .AVG_LOG2(2), .GAP_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .adc_cs_n(cs_n_b), .adc_sclk(sclk_b),
      .adc_din(din_b), .adc_miso(miso), .adc_dout(dout_b), .adc_valid(valid_b));

   adc_spi_sampler #(.CLK_DIV(2), .CHANNEL(3), .AVG_LOG2(4), .GAP_CYCLES(4)) dut_c (
      .clk(clk), .rst(rst), .enable(enable), .adc_cs_n(cs_n_c), .adc_sclk(sclk_c),
      .adc_din(din_c), .adc_miso(miso), .adc_dout(dout_c), .adc_valid(valid_c));

   // ADC model: one table entry per frame, data shifted out on falling sclk
   logic [11:0] val_tab [256];
   logic [15:0] m_word = '0;
   int          m_fall = 0;
   int          frm = 0;
   logic [15:0] din_sr = '0;
   logic [15:0] din_last = '0;
   int          rise_cnt = 0;
   int          rise_last = 0;
   int          cyc = 0;
   int          vcnt_b = 0;
   int          vcnt_c = 0;

   always @(negedge cs_n_a) begin
      m_word   = {4'd0, val_tab[frm % 256]};
      frm      = frm + 1;
      m_fall   = 0;
      din_sr   = '0;
      rise_cnt = 0;
   end

   always @(negedge sclk_a) begin
      if (cs_n_a === 1'b0 && m_fall < 16) begin
         miso   = m_word[15 - m_fall];
         m_fall = m_fall + 1;
      end
   end

   always @(posedge sclk_a) begin
      if (cs_n_a === 1'b0) begin
         din_sr   = {din_sr[14:0], din_a};
         rise_cnt = rise_cnt + 1;
      end
   end

   always @(posedge cs_n_a) begin
      din_last  = din_sr;
      rise_last = rise_cnt;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_b === 1'b1) vcnt_b = vcnt_b + 1;
      if (valid_c === 1'b1) vcnt_c = vcnt_c + 1;
   end

   task automatic wait_rise(input int bound, output int low_cnt);
      int   i;
      logic prev;
      bit   ok;
      prev = cs_n_a; low_cnt = 0; ok = 0; i = 0;
      while (!ok && i < bound) begin
         @(negedge clk);
         i++;
         if (cs_n_a === 1'b0) low_cnt++;
         if (cs_n_a === 1'b1 && prev === 1'b0) ok = 1;
         prev = cs_n_a;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_cs_rise: no cs_n rise within %0d cycles", bound);
      end
   endtask

   task automatic wait_fall(input int bound);
      int   i;
      logic prev;
      bit   ok;
      prev = cs_n_a; ok = 0; i = 0;
      while (!ok && i < bound) begin
         @(negedge clk);
         i++;
         if (cs_n_a === 1'b0 && prev === 1'b1) ok = 1;
         prev = cs_n_a;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_cs_fall: no cs_n fall within %0d cycles", bound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (cs_n_a !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
      n_tests++; if (sclk_a !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", sclk_a); end
      n_tests++; if (din_a !== 1'b0) begin n_fail++; $display("FAIL reset_din: got %b want 0", din_a); end
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
      n_tests++; if (dout_a !== 12'd4095) begin n_fail++; $display("FAIL reset_dout_a: got %0d want 4095", dout_a); end
      n_tests++; if (dout_c !== 12'd4095) begin n_fail++; $display("FAIL reset_dout_c: got %0d want 4095", dout_c); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (cs_n_a !== 1'b1) begin n_fail++; $display("FAIL idle_cs_n: got %b want 1", cs_n_a); end
   endtask

   task automatic test_basic_capture();
      int base, lc, c1;
      base = frm;
      val_tab[base % 256] = 12'd100;
      for (int i = 1; i < 8; i++) val_tab[(base + i) % 256] = 12'd3600;
      enable = 1'b1;
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_priming_valid: got %b want 0", valid_a); end
      n_tests++; if (dout_a !== 12'd4095) begin n_fail++; $display("FAIL basic_priming_dout: got %0d want 4095", dout_a); end
      c1 = cyc;
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid_a); end
      n_tests++; if (dout_a !== 12'd3600) begin n_fail++; $display("FAIL basic_dout: got %0d want 3600", dout_a); end
      n_tests++; if (lc != 68) begin n_fail++; $display("FAIL basic_cs_low: got %0d want 68", lc); end
      n_tests++; if (cyc - c1 != 72) begin n_fail++; $display("FAIL basic_period: got %0d want 72", cyc - c1); end
      @(negedge clk);
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %b want 0", valid_a); end
      n_tests++; if (din_last !== 16'h2800) begin n_fail++; $display("FAIL addr_din_word: got %h want 2800", din_last); end
      n_tests++; if (rise_last != 16) begin n_fail++; $display("FAIL addr_rise_count: got %0d want 16", rise_last); end
   endtask

   task automatic test_enable_drop();
      int base, lc, seen;
      base = frm;
      for (int i = 0; i < 4; i++) val_tab[(base + i) % 256] = 12'd3000;
      wait_fall(200);
      repeat (30) @(negedge clk);
      n_tests++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL drop_in_low_phase: sclk got %b want 0", sclk_a); end
      enable = 1'b0;
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %b want 1", valid_a); end
      n_tests++; if (dout_a !== 12'd3000) begin n_fail++; $display("FAIL drop_dout: got %0d want 3000", dout_a); end
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (cs_n_a !== 1'b1) seen++;
      end
      n_tests++; if (seen != 0) begin n_fail++; $display("FAIL drop_cs_idle: cs_n low %0d cycles want 0", seen); end
      base = frm;
      val_tab[base % 256] = 12'd1500;
      for (int i = 1; i < 4; i++) val_tab[(base + i) % 256] = 12'd2200;
      enable = 1'b1;
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reenable_priming_valid: got %b want 0", valid_a); end
      n_tests++; if (dout_a !== 12'd3000) begin n_fail++; $display("FAIL reenable_hold_dout: got %0d want 3000", dout_a); end
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL reenable_valid: got %b want 1", valid_a); end
      n_tests++; if (dout_a !== 12'd2200) begin n_fail++; $display("FAIL reenable_dout: got %0d want 2200", dout_a); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int base, lc;
      base = frm;
      val_tab[base % 256]       = 12'd1111;
      val_tab[(base + 1) % 256] = 12'd700;
      for (int i = 2; i < 6; i++) val_tab[(base + i) % 256] = 12'd2500;
      wait_fall(200);
      repeat (42) @(negedge clk);
      n_tests++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_sclk: got %b want 0", sclk_a); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++; if (cs_n_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n_a); end
      n_tests++; if (sclk_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_sclk: got %b want 1", sclk_a); end
      n_tests++; if (dout_a !== 12'd4095) begin n_fail++; $display("FAIL rstmid_dout: got %0d want 4095", dout_a); end
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_a); end
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_priming_valid: got %b want 0", valid_a); end
      n_tests++; if (dout_a !== 12'd4095) begin n_fail++; $display("FAIL rstmid_priming_dout: got %0d want 4095", dout_a); end
      wait_rise(200, lc);
      n_tests++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_after: got %b want 1", valid_a); end
      n_tests++; if (dout_a !== 12'd2500) begin n_fail++; $display("FAIL rstmid_dout_after: got %0d want 2500", dout_a); end
      @(negedge clk);
   endtask

   task automatic test_averaging();
      int base, lc, vb0;
      rst = 1'b1; enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = frm;
      val_tab[base % 256] = 12'd999;
      for (int i = 1; i <= 4; i++) val_tab[(base + i) % 256] = 12'(3549 + i);
      for (int i = 5; i < 8; i++) val_tab[(base + i) % 256] = 12'd0;
      vb0 = vcnt_b;
      enable = 1'b1;
      for (int f = 0; f < 4; f++) begin
         wait_rise(200, lc);
         n_tests++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL avg_no_valid_f%0d: got %b want 0", f, valid_b); end
      end
      n_tests++; if (dout_b !== 12'd4095) begin n_fail++; $display("FAIL avg_hold_dout: got %0d want 4095", dout_b); end
      wait_rise(200, lc);
      n_tests++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL avg_valid: got %b want 1", valid_b); end
      n_tests++; if (dout_b !== 12'd3551) begin n_fail++; $display("FAIL avg_dout: got %0d want 3551", dout_b); end
      n_tests++; if (dout_a !== 12'd3553) begin n_fail++; $display("FAIL avg_passthru_a: got %0d want 3553", dout_a); end
      @(negedge clk);
      n_tests++; if (vcnt_b - vb0 != 1) begin n_fail++; $display("FAIL avg_valid_count: got %0d want 1", vcnt_b - vb0); end
   endtask

   task automatic test_full_scale();
      int base, lc, vc0;
      rst = 1'b1; enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = frm;
      val_tab[base % 256] = 12'd0;
      for (int i = 1; i < 20; i++) val_tab[(base + i) % 256] = 12'd4095;
      vc0 = vcnt_c;
      enable = 1'b1;
      for (int f = 0; f < 16; f++) begin
         wait_rise(200, lc);
         n_tests++; if (valid_c !== 1'b0) begin n_fail++; $display("FAIL full_no_valid_f%0d: got %b want 0", f, valid_c); end
      end
      wait_rise(200, lc);
      n_tests++; if (valid_c !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", valid_c); end
      n_tests++; if (dout_c !== 12'd4095) begin n_fail++; $display("FAIL full_dout: got %0d want 4095", dout_c); end
      n_tests++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL full_valid_b: got %b want 1", valid_b); end
      n_tests++; if (dout_b !== 12'd4095) begin n_fail++; $display("FAIL full_dout_b: got %0d want 4095", dout_b); end
      @(negedge clk);
      n_tests++; if (vcnt_c - vc0 != 1) begin n_fail++; $display("FAIL full_valid_count: got %0d want 1", vcnt_c - vc0); end
      enable = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) val_tab[i] = 12'd0;
      test_reset();
      test_basic_capture();
      test_enable_drop();
      test_reset_mid_frame();
      test_averaging();
      test_full_scale();
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
